// File: rtl/lif_neuron_layer.sv
// lif_neuron_layer: time-multiplexed layer of leaky integrate-and-fire neurons.
// One shared binary-weight accumulate / decay / reset datapath evaluates one
// neuron per clock. An accepted input spike vector runs one timestep across all
// neurons and produces one output spike vector.
//
// Optional feature macro: LIF_REFRACTORY_EN
//   When defined, adds parameter REFRACTORY_STEPS and a per-neuron refractory
//   counter that blocks input and firing for that many timesteps after a spike.
module lif_neuron_layer #(
  parameter int N_INPUTS      = 8,
  parameter int N_NEURONS     = 4,
  parameter int MEMBRANE_BITS = 6
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int REFRACTORY_STEPS = 2
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     cfg_shift,
  input  logic [MEMBRANE_BITS-2:0]       cfg_threshold,
  input  logic                           w_we,
  input  logic [$clog2(N_NEURONS)-1:0]   w_addr,
  input  logic [N_INPUTS-1:0]            w_row,
  input  logic                           clear_state,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUTS-1:0]            in_spikes,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_NEURONS-1:0]           out_spikes,
  output logic                           busy
);

  localparam int IDX_W = $clog2(N_NEURONS);
  // Two guard bits cover psp + decayed membrane - threshold without wrap.
  localparam int ACC_W = MEMBRANE_BITS + 2;

  localparam logic [IDX_W-1:0]        IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_NEURONS - 1);
  localparam logic signed [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] U_MAX    = {3'b000, {(MEMBRANE_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] U_MIN    = {3'b111, {(MEMBRANE_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                           state_r;
  state_t                           state_next_s;
  logic [IDX_W-1:0]                 idx_r;
  logic                             idx_last_s;
  logic [N_INPUTS-1:0]              in_lat_r;
  logic [N_INPUTS-1:0]              w_r [N_NEURONS];
  logic signed [MEMBRANE_BITS-1:0]  mem_r [N_NEURONS];
  logic [N_NEURONS-1:0]             spike_r;
  logic                             in_ready_r;
  logic                             out_valid_r;
  logic                             busy_r;

  // Shared datapath signals for the neuron selected by idx_r.
  logic signed [ACC_W-1:0]          psp_s;
  logic signed [ACC_W-1:0]          psp_eff_s;
  logic signed [ACC_W-1:0]          u_ext_s;
  logic signed [ACC_W-1:0]          decayed_s;
  logic signed [ACC_W-1:0]          thr_s;
  logic signed [ACC_W-1:0]          sub_s;
  logic signed [ACC_W-1:0]          acc_s;
  logic signed [ACC_W-1:0]          sat_s;
  logic signed [MEMBRANE_BITS-1:0]  new_u_s;
  logic                             fire_s;
  logic                             spike_s;
  logic                             refr_s;

  // Binary-weight dot product: active inputs add +1 where the weight bit is 1
  // and -1 where it is 0; inactive inputs contribute nothing.
  function automatic logic signed [ACC_W-1:0] binary_dot(
    input logic [N_INPUTS-1:0] spikes,
    input logic [N_INPUTS-1:0] row
  );
    logic signed [ACC_W-1:0] sum;
    sum = '0;
    for (int j = 0; j < N_INPUTS; j++) begin
      if (spikes[j]) begin
        if (row[j]) begin
          sum = sum + ACC_ONE;
        end else begin
          sum = sum - ACC_ONE;
        end
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  assign idx_last_s = (idx_r == IDX_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_COMPUTE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (idx_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_COMPUTE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Input latch, neuron index and registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_lat_r    <= '0;
      idx_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            in_lat_r <= in_spikes;
            idx_r    <= '0;
          end
        end
        ST_COMPUTE: begin
          if (!idx_last_s) begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Weight rows may only change between timesteps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        w_r[i] <= '0;
      end
    end else if ((state_r == ST_IDLE) && w_we && (int'(w_addr) < N_NEURONS)) begin
      w_r[w_addr] <= w_row;
    end
  end

`ifdef LIF_REFRACTORY_EN
  localparam int REF_W = $clog2(REFRACTORY_STEPS + 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRACTORY_STEPS);
  localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);

  logic [REF_W-1:0] ref_cnt_r [N_NEURONS];

  assign refr_s = (ref_cnt_r[idx_r] != '0);

  // Refractory counter of the neuron being evaluated: count down while
  // refractory, reload on a fresh spike.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        ref_cnt_r[i] <= '0;
      end
    end else if (state_r == ST_COMPUTE) begin
      if (refr_s) begin
        ref_cnt_r[idx_r] <= ref_cnt_r[idx_r] - REF_ONE;
      end else if (fire_s) begin
        ref_cnt_r[idx_r] <= REF_LOAD;
      end
    end
  end
`else
  assign refr_s = 1'b0;
`endif

  // Leak, integrate, subtract-on-spike and saturate for the selected neuron.
  always_comb begin
    psp_s     = binary_dot(in_lat_r, w_r[idx_r]);
    psp_eff_s = psp_s;
    if (refr_s) begin
      psp_eff_s = '0;
    end else begin
      psp_eff_s = psp_s;
    end
    u_ext_s = {{2{mem_r[idx_r][MEMBRANE_BITS-1]}}, mem_r[idx_r]};
    // Shift 0 means no leak rather than a full discharge.
    if (cfg_shift == 3'd0) begin
      decayed_s = u_ext_s;
    end else begin
      decayed_s = u_ext_s - (u_ext_s >>> cfg_shift);
    end
    thr_s = {3'b000, cfg_threshold};
    if (spike_r[idx_r]) begin
      sub_s = thr_s;
    end else begin
      sub_s = '0;
    end
    acc_s = psp_eff_s + decayed_s - sub_s;
    if (acc_s > U_MAX) begin
      sat_s = U_MAX;
    end else if (acc_s < U_MIN) begin
      sat_s = U_MIN;
    end else begin
      sat_s = acc_s;
    end
    new_u_s = sat_s[MEMBRANE_BITS-1:0];
    fire_s  = (sat_s >= thr_s);
    spike_s = fire_s & ~refr_s;
  end

  // Per-neuron membrane and spike state; clear only between timesteps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i] <= '0;
      end
      spike_r <= '0;
    end else if ((state_r == ST_IDLE) && clear_state) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i] <= '0;
      end
      spike_r <= '0;
    end else if (state_r == ST_COMPUTE) begin
      mem_r[idx_r]   <= new_u_s;
      spike_r[idx_r] <= spike_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_spikes = spike_r;

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Testbench for lif_neuron_layer (N_INPUTS=4, N_NEURONS=4, MEMBRANE_BITS=6).
// A timestep-level model computes membranes and spikes with plain integer
// arithmetic; a compare process checks out_spikes whenever out_valid is high.
module tb_lif_neuron_layer;

  localparam int NI = 4;
  localparam int NN = 4;
  localparam int MB = 6;
`ifdef LIF_REFRACTORY_EN
  localparam int REF_STEPS = 2;
  localparam int U0_STEP3  = 3;
`else
  localparam int REF_STEPS = 0;
  localparam int U0_STEP3  = 7;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    cfg_shift;
  logic [MB-2:0] cfg_threshold;
  logic          w_we;
  logic [1:0]    w_addr;
  logic [NI-1:0] w_row;
  logic          clear_state;
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] in_spikes;
  logic          out_valid;
  logic          out_ready;
  logic [NN-1:0] out_spikes;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Timestep-level model state.
  int            mu [NN];
  bit            ms [NN];
  logic [NI-1:0] wm [NN];
  int            rc [NN];
  logic [NN-1:0] exp_spk;

  lif_neuron_layer #(
    .N_INPUTS(NI),
    .N_NEURONS(NN),
    .MEMBRANE_BITS(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_shift(cfg_shift),
    .cfg_threshold(cfg_threshold),
    .w_we(w_we),
    .w_addr(w_addr),
    .w_row(w_row),
    .clear_state(clear_state),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_spikes(in_spikes),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_spikes(out_spikes),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NN; i++) begin
      mu[i] = 0; ms[i] = 1'b0; wm[i] = '0; rc[i] = 0;
    end
    exp_spk = '0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < NN; i++) begin
      mu[i] = 0; ms[i] = 1'b0;
    end
    exp_spk = '0;
  endtask

  // One whole timestep of the layer, straight from the neuron equations.
  task automatic m_step(input logic [NI-1:0] sp, input int thr, input int sh);
    for (int i = 0; i < NN; i++) begin
      int psp;
      int dec;
      int acc;
      bit spk;
      psp = 0;
      for (int j = 0; j < NI; j++) begin
        if (sp[j]) psp += wm[i][j] ? 1 : -1;
      end
      if (rc[i] != 0) psp = 0;
      dec = (sh == 0) ? mu[i] : mu[i] - (mu[i] >>> sh);
      acc = psp + dec - (ms[i] ? thr : 0);
      if (acc > 31) acc = 31;
      if (acc < -32) acc = -32;
      spk = (acc >= thr);
      if (rc[i] != 0) begin
        spk = 1'b0;
        rc[i] = rc[i] - 1;
      end else if (spk) begin
        rc[i] = REF_STEPS;
      end
      mu[i] = acc;
      ms[i] = spk;
      exp_spk[i] = spk;
    end
  endtask

  // Output spikes must match the model on every cycle they are presented.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      chk("out_spikes", 32'(out_spikes), 32'(exp_spk));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      chk("busy_done", 32'(busy), 32'd1);
    end
  end

  task automatic write_w(input logic [1:0] a, input logic [NI-1:0] row);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_row = row;
    @(posedge clk);
    wm[a] = row;
    #1 w_we = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_state = 1'b1;
    @(posedge clk);
    m_clear();
    #1 clear_state = 1'b0;
  endtask

  // Runs one timestep; optional write/clear coincide with the accept, and
  // hold > 0 keeps out_ready low for that many cycles with lockout probes.
  task automatic run_step(input logic [NI-1:0] sp, input int thr, input int sh,
                          input bit clr, input bit we, input logic [1:0] wa,
                          input logic [NI-1:0] wr, input int hold);
    int n;
    @(negedge clk);
    cfg_threshold = 5'(thr); cfg_shift = 3'(sh);
    in_spikes = sp; in_valid = 1'b1;
    clear_state = clr; w_we = we; w_addr = wa; w_row = wr;
    out_ready = (hold == 0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (clr) m_clear();
    if (we) wm[wa] = wr;
    m_step(sp, thr, sh);
    #1;
    in_valid = 1'b0; clear_state = 1'b0; w_we = 1'b0;
    // n counts clock edges starting with the accept edge.
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(NN + 1));
    for (int i = 0; i < NN; i++) begin
      chk($sformatf("u%0d", i), 32'(int'(dut.mem_r[i])), 32'(mu[i]));
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = 2'd0; w_row = ~wm[0]; clear_state = 1'b1;
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    w_we = 1'b0; clear_state = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int exp_u1 [4];
    int exp_u2 [4];
    exp_u1 = '{-4, -2, -1, 0};
    exp_u2 = '{4, 2, 1, 1};
    reset = 1'b1; cfg_shift = 3'd0; cfg_threshold = 5'd5;
    w_we = 1'b0; w_addr = 2'd0; w_row = 4'd0; clear_state = 1'b0;
    in_valid = 1'b0; in_spikes = 4'd0; out_ready = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_spikes", 32'(out_spikes), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Integrate and fire on neuron 0, negative saturation on neuron 1.
    write_w(2'd0, 4'b1111);
    write_w(2'd1, 4'b0000);
    write_w(2'd2, 4'b0011);
    write_w(2'd3, 4'b1010);
    for (int s = 1; s <= 10; s++) begin
      run_step(4'b1111, 5, 0, 1'b0, 1'b0, 2'd0, 4'd0, 0);
      if (s == 1) begin
        chk("pin_u0_s1", 32'(int'(dut.mem_r[0])), 32'd4);
        chk("pin_spk0_s1", 32'(out_spikes[0]), 32'd0);
      end
      if (s == 2) begin
        chk("pin_u0_s2", 32'(int'(dut.mem_r[0])), 32'd8);
        chk("pin_spk0_s2", 32'(out_spikes[0]), 32'd1);
      end
      if (s == 3) chk("pin_u0_s3", 32'(int'(dut.mem_r[0])), 32'(U0_STEP3));
      if (s == 4) chk("pin_u1_s4", 32'(int'(dut.mem_r[1])), 32'(-16));
    end
    chk("pin_u1_sat", 32'(int'(dut.mem_r[1])), 32'(-32));
    chk("pin_spk1_sat", 32'(out_spikes[1]), 32'd0);

    // Decay: u2 rises to 8, u1 to -8, then leak with shift 1.
    do_clear();
    write_w(2'd2, 4'b1111);
    run_step(4'b1111, 9, 0, 1'b0, 1'b0, 2'd0, 4'd0, 0);
    run_step(4'b1111, 9, 0, 1'b0, 1'b0, 2'd0, 4'd0, 0);
    chk("pin_u2_8", 32'(int'(dut.mem_r[2])), 32'd8);
    for (int s = 0; s < 4; s++) begin
      run_step(4'b0000, 9, 1, 1'b0, 1'b0, 2'd0, 4'd0, 0);
      chk($sformatf("pin_decay_u2_%0d", s), 32'(int'(dut.mem_r[2])), 32'(exp_u2[s]));
      chk($sformatf("pin_decay_u1_%0d", s), 32'(int'(dut.mem_r[1])), 32'(exp_u1[s]));
    end

    // Backpressure: DONE held 5 cycles while write and clear are attempted.
    run_step(4'b1111, 5, 0, 1'b0, 1'b0, 2'd0, 4'd0, 5);
    chk("w0_locked", 32'(dut.w_r[0]), 32'(4'b1111));
    run_step(4'b1111, 5, 0, 1'b0, 1'b0, 2'd0, 4'd0, 0);

    // Write and clear coinciding with the accept apply before the step.
    run_step(4'b0101, 3, 2, 1'b1, 1'b1, 2'd3, 4'b0101, 0);
    chk("pin_u3_coincide", 32'(int'(dut.mem_r[3])), 32'd2);

    // Threshold 0: a membrane of 0 fires.
    run_step(4'b0000, 0, 0, 1'b1, 1'b0, 2'd0, 4'd0, 0);
    run_step(4'b0110, 0, 3, 1'b0, 1'b0, 2'd0, 4'd0, 0);

    // Asynchronous reset in the middle of COMPUTE.
    @(negedge clk);
    in_spikes = 4'b1111; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_spikes", 32'(out_spikes), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    // Weights were cleared, so every active input counts -1.
    run_step(4'b1111, 5, 0, 1'b0, 1'b0, 2'd0, 4'd0, 0);
    chk("pin_u0_after_rst", 32'(int'(dut.mem_r[0])), 32'(-4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
